// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Shared constants, state encoding and helpers for the memory port arbiters.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] SEL_IF  = 2'b00;
  localparam logic [1:0] SEL_LSU = 2'b01;
  localparam logic [1:0] SEL_DBG = 2'b10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int WAIT_W = 8;

  // Modulo-3 increment; an out-of-range input folds back to requester 0.
  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x >= SEL_DBG) ? SEL_IF : x + 2'd1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot3(input logic [1:0] s);
    logic [NUM_REQ-1:0] v;
    case (s)
      SEL_IF:  v = 3'b001;
      SEL_LSU: v = 3'b010;
      SEL_DBG: v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick3.sv
// ============================================================================
// Module   : rr_pick3
// Combinational 3-way winner pick: round-robin after 'last', or fixed 0>1>2.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick3
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  input  logic               mode,
  output logic [1:0]         winner,
  output logic               any
);

  logic [1:0] w_c0;
  logic [1:0] w_c1;
  logic [1:0] w_c2;

  always_comb begin
    if (mode) begin
      w_c0 = SEL_IF;
      w_c1 = SEL_LSU;
      w_c2 = SEL_DBG;
    end else begin
      w_c0 = inc3(last);
      w_c1 = inc3(w_c0);
      w_c2 = inc3(w_c1);
    end

    winner = SEL_IF;
    if (req[w_c0])      winner = w_c0;
    else if (req[w_c1]) winner = w_c1;
    else if (req[w_c2]) winner = w_c2;
  end

  assign any = |req;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Grants one shared memory port to fetch/LSU/debug, one transaction at a time.
// Define MEM_ARB_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES without ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] err,
  output logic [1:0]         sel,
  output logic               mem_valid,
  input  logic               mem_ready,
  output logic               busy
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_bad
    $error("mem_port_arbiter: TIMEOUT_CYCLES must be within 2..255");
  end

  logic [0:0]         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic [NUM_REQ-1:0] r_err;
  logic [1:0]         r_sel;
  logic               r_mem_valid;
  logic [1:0]         r_rr_last;

  logic [0:0]         w_state_nxt;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic [NUM_REQ-1:0] w_done_nxt;
  logic [NUM_REQ-1:0] w_err_nxt;
  logic [1:0]         w_sel_nxt;
  logic               w_mem_valid_nxt;
  logic [1:0]         w_rr_last_nxt;

  logic [1:0]         w_winner;
  logic               w_any;
  logic               w_timeout;
  logic               w_mode;

  assign w_mode = (PRIORITY_MODE != 0);

  rr_pick3 u_pick (
    .req    (req),
    .last   (r_rr_last),
    .mode   (w_mode),
    .winner (w_winner),
    .any    (w_any)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] r_wait;

  // Held at zero in IDLE so every transaction starts counting from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_wait <= '0;
    else if (r_state == ST_IDLE) r_wait <= '0;
    else if (!mem_ready)         r_wait <= r_wait + WAIT_W'(1);
  end

  assign w_timeout = (r_state == ST_BUSY) && !mem_ready && (r_wait == c_wait_last);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_sel       <= SEL_IF;
      r_mem_valid <= 1'b0;
      r_rr_last   <= SEL_DBG;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_sel       <= w_sel_nxt;
      r_mem_valid <= w_mem_valid_nxt;
      r_rr_last   <= w_rr_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any)                   w_state_nxt = ST_BUSY;
      ST_BUSY: if (mem_ready || w_timeout)  w_state_nxt = ST_IDLE;
      default:                              w_state_nxt = ST_IDLE;
    endcase
  end

  // mem_ready takes precedence over a coinciding timeout.
  always_comb begin
    w_gnt_nxt       = r_gnt;
    w_sel_nxt       = r_sel;
    w_mem_valid_nxt = r_mem_valid;
    w_rr_last_nxt   = r_rr_last;
    w_done_nxt      = '0;
    w_err_nxt       = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_gnt_nxt       = onehot3(w_winner);
          w_sel_nxt       = w_winner;
          w_mem_valid_nxt = 1'b1;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          w_gnt_nxt       = '0;
          w_mem_valid_nxt = 1'b0;
          w_done_nxt      = r_gnt;
          w_rr_last_nxt   = r_sel;
        end else if (w_timeout) begin
          w_gnt_nxt       = '0;
          w_mem_valid_nxt = 1'b0;
          w_err_nxt       = r_gnt;
          w_rr_last_nxt   = r_sel;
        end
      end
      default: begin
        w_gnt_nxt       = '0;
        w_mem_valid_nxt = 1'b0;
      end
    endcase
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign err       = r_err;
  assign sel       = r_sel;
  assign mem_valid = r_mem_valid;
  assign busy      = (r_state == ST_BUSY);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Directed bench: round-robin and fixed-priority instances with a grant/done scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic       mem_ready;

  logic [2:0] a_gnt, a_done, a_err;
  logic [1:0] a_sel;
  logic       a_mem_valid, a_busy;
  logic [2:0] b_gnt, b_done, b_err;
  logic [1:0] b_sel;
  logic       b_mem_valid, b_busy;

  int total = 0;
  int bad   = 0;
  logic mon_b = 1'b0;

  logic [1:0] exp_sel_q[$];
  logic [3:0] exp_end_q[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(4)) u_rr (
    .clk(clk), .rst(rst), .req(req), .gnt(a_gnt), .done(a_done), .err(a_err),
    .sel(a_sel), .mem_valid(a_mem_valid), .mem_ready(mem_ready), .busy(a_busy)
  );

  mem_port_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(4)) u_fp (
    .clk(clk), .rst(rst), .req(req), .gnt(b_gnt), .done(b_done), .err(b_err),
    .sel(b_sel), .mem_valid(b_mem_valid), .mem_ready(mem_ready), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic inv(input string pfx, input logic [2:0] g, input logic [1:0] s,
                     input logic v, input logic bz, input logic [2:0] d, input logic [2:0] e);
    chk({pfx, "_gnt_onehot0"}, 16'($onehot0(g)), 1);
    chk({pfx, "_sel_not3"},    16'(s != 2'b11), 1);
    chk({pfx, "_valid_eq_gnt"}, 16'(v), 16'(|g));
    chk({pfx, "_busy_eq_valid"}, 16'(bz), 16'(v));
    chk({pfx, "_done_err_excl"}, 16'((|d) && (|e)), 0);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Scoreboard monitor: checks each new grant and each completion pulse.
  logic [2:0] m_prev = 3'b000;
  always @(negedge clk) begin
    logic [2:0] mg, md, me, oh;
    logic [1:0] ms, es;
    logic [3:0] ee;
    mg = mon_b ? b_gnt  : a_gnt;
    md = mon_b ? b_done : a_done;
    me = mon_b ? b_err  : a_err;
    ms = mon_b ? b_sel  : a_sel;
    inv("rr", a_gnt, a_sel, a_mem_valid, a_busy, a_done, a_err);
    inv("fp", b_gnt, b_sel, b_mem_valid, b_busy, b_done, b_err);
    if (mg != 3'b000 && m_prev == 3'b000) begin
      if (exp_sel_q.size() == 0) begin
        chk("unexpected_grant", 16'(mg), 0);
      end else begin
        es = exp_sel_q.pop_front();
        oh = 3'b001 << es;
        chk("grant_sel", 16'(ms), 16'(es));
        chk("grant_vec", 16'(mg), 16'(oh));
      end
    end
    if ((md | me) != 3'b000) begin
      if (exp_end_q.size() == 0) begin
        chk("unexpected_end", 16'({|me, md | me}), 0);
      end else begin
        ee = exp_end_q.pop_front();
        chk("end_pulse", 16'({|me, md | me}), 16'(ee));
      end
    end
    m_prev = mg;
  end

  initial begin
    rst = 1'b1;
    req = 3'b000;
    mem_ready = 1'b0;
    step();
    step();
    chk("reset_rr", 16'({a_gnt, a_done, a_err, a_sel, a_mem_valid, a_busy}), 0);
    chk("reset_fp", 16'({b_gnt, b_done, b_err, b_sel, b_mem_valid, b_busy}), 0);
    rst = 1'b0;

    // Single request, ready on the 3rd BUSY cycle
    req = 3'b001;
    exp_sel_q.push_back(2'b00);
    step();
    chk("t1_gnt", 16'(a_gnt), 16'b001);
    chk("t1_sel", 16'(a_sel), 0);
    chk("t1_busy", 16'(a_busy), 1);
    req = 3'b000;
    step();
    step();
    mem_ready = 1'b1;
    exp_end_q.push_back(4'b0001);
    step();
    chk("t1_done", 16'(a_done), 16'b001);
    chk("t1_idle", 16'({a_busy, a_mem_valid, a_gnt}), 0);
    chk("t1_sel_hold", 16'(a_sel), 0);
    step();
    chk("t1_ready_idle_ignored", 16'({a_busy, a_done}), 0);
    mem_ready = 1'b0;
    step();
    chk("t1_done_one_cycle", 16'(a_done), 0);

    // Round-robin, all requests held, immediate ready
    do_reset();
    req = 3'b111;
    mem_ready = 1'b1;
    exp_sel_q.push_back(2'b00); exp_end_q.push_back(4'b0001);
    exp_sel_q.push_back(2'b01); exp_end_q.push_back(4'b0010);
    exp_sel_q.push_back(2'b10); exp_end_q.push_back(4'b0100);
    exp_sel_q.push_back(2'b00); exp_end_q.push_back(4'b0001);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2_busy_alternate", 16'(a_busy), 16'(i % 2 == 0));
    end
    req = 3'b000;
    mem_ready = 1'b0;
    step();

    // Fixed priority: requester 2 starves behind 1
    do_reset();
    mon_b = 1'b1;
    req = 3'b110;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_sel_q.push_back(2'b01);
      exp_end_q.push_back(4'b0010);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t3_busy_alternate", 16'(b_busy), 16'(i % 2 == 0));
    end
    req = 3'b100;
    exp_sel_q.push_back(2'b10);
    exp_end_q.push_back(4'b0100);
    step();
    chk("t3_sel_dbg", 16'(b_sel), 16'b10);
    step();
    chk("t3_done_dbg", 16'(b_done), 16'b100);
    req = 3'b000;
    mem_ready = 1'b0;
    step();
    do_reset();
    mon_b = 1'b0;

    // Granted requester drops req mid-BUSY; pending requester 2 follows
    req = 3'b110;
    exp_sel_q.push_back(2'b01);
    step();
    chk("t4_sel_lsu", 16'(a_sel), 16'b01);
    req = 3'b100;
    step();
    step();
    chk("t4_still_busy", 16'(a_gnt), 16'b010);
    mem_ready = 1'b1;
    exp_end_q.push_back(4'b0010);
    step();
    chk("t4_done_lsu", 16'(a_done), 16'b010);
    mem_ready = 1'b0;
    exp_sel_q.push_back(2'b10);
    step();
    chk("t4_gnt_dbg", 16'(a_gnt), 16'b100);
    mem_ready = 1'b1;
    exp_end_q.push_back(4'b0100);
    step();
    chk("t4_done_dbg", 16'(a_done), 16'b100);
    mem_ready = 1'b0;
    req = 3'b000;
    step();

    // Asynchronous reset while BUSY
    req = 3'b001;
    exp_sel_q.push_back(2'b00);
    step();
    chk("t5_busy", 16'(a_busy), 1);
    req = 3'b000;
    step();
    rst = 1'b1;
    #1;
    chk("t5_async_clear", 16'({a_gnt, a_done, a_err, a_sel, a_mem_valid, a_busy}), 0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("t5_no_done", 16'(a_done), 0);
    req = 3'b100;
    exp_sel_q.push_back(2'b10);
    step();
    chk("t5_sel_after_reset", 16'(a_sel), 16'b10);
    mem_ready = 1'b1;
    exp_end_q.push_back(4'b0100);
    step();
    chk("t5_done", 16'(a_done), 16'b100);
    mem_ready = 1'b0;
    req = 3'b000;
    step();

`ifdef MEM_ARB_TIMEOUT_EN
    // Timeout after 4 BUSY cycles without ready
    req = 3'b001;
    exp_sel_q.push_back(2'b00);
    step();
    req = 3'b000;
    step();
    step();
    step();
    chk("t6_busy_cycle4", 16'(a_busy), 1);
    exp_end_q.push_back(4'b1001);
    step();
    chk("t6_err", 16'(a_err), 16'b001);
    chk("t6_no_done", 16'(a_done), 0);
    chk("t6_idle", 16'(a_busy), 0);
    step();
    chk("t6_err_one_cycle", 16'(a_err), 0);
    // Ready on the timeout cycle wins
    req = 3'b001;
    exp_sel_q.push_back(2'b00);
    step();
    req = 3'b000;
    step();
    step();
    step();
    mem_ready = 1'b1;
    exp_end_q.push_back(4'b0001);
    step();
    chk("t6_done_wins", 16'(a_done), 16'b001);
    chk("t6_no_err", 16'(a_err), 0);
    mem_ready = 1'b0;
    step();
`else
    // Without timeout, BUSY waits indefinitely and err stays 0
    req = 3'b001;
    exp_sel_q.push_back(2'b00);
    step();
    req = 3'b000;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t6_wait_forever", 16'({a_busy, a_err}), 16'b1000);
    end
    mem_ready = 1'b1;
    exp_end_q.push_back(4'b0001);
    step();
    chk("t6_done_late", 16'(a_done), 16'b001);
    mem_ready = 1'b0;
    step();
`endif

    step();
    chk("sel_queue_drained", 16'(exp_sel_q.size()), 0);
    chk("end_queue_drained", 16'(exp_end_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
